// File: rtl/stage_sample_output_pkg.sv
// Shared constants and types for the I2S sample output stage.
package stage_sample_output_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned I2S_SLOTS = 32;
  localparam int unsigned SLOT_W    = $clog2(I2S_SLOTS);
  localparam int unsigned FRAME_W   = 2 * SAMPLE_W;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // LRCLK polarity: left channel is driven low.
  typedef enum logic {
    LR_LEFT  = 1'b0,
    LR_RIGHT = 1'b1
  } lr_chan_e;

  // Upper half of the frame's slots belongs to the right channel.
  function automatic lr_chan_e slot_channel(input logic [SLOT_W-1:0] slot);
    return slot[SLOT_W-1] ? LR_RIGHT : LR_LEFT;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO: push/pop, empty, level, and a drop strobe when a push
// hits a full FIFO that is not being popped in the same cycle.
module sample_fifo
  import stage_sample_output_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = SAMPLE_W,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic [AW:0]      o_level,
  output logic             o_drop
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // Status and handshake qualification; a pop frees a slot for a same-cycle push.
  always_comb begin
    w_full    = (r_level == LVL_FULL);
    o_empty   = (r_level == '0);
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!w_full || w_do_pop);
    o_drop    = i_push && w_full && !w_do_pop;
    o_head    = r_mem[r_rd_ptr];
    o_level   = r_level;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks net change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/stage_sample_output.sv
// I2S output stage: buffers mixed mono samples and serializes each one as a
// Philips I2S frame (16 bits per channel, 32 slots), duplicated left/right.
module stage_sample_output
  import stage_sample_output_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BCLK_HALF  = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic                        i_SampleReady,
  input  logic [SAMPLE_W-1:0]         i_Sample,
  input  logic                        i_ClearFlags,
  output logic                        o_BitClock,
  output logic                        o_LeftRightClock,
  output logic                        o_SerialData,
  output logic [$clog2(FIFO_DEPTH):0] o_FifoLevel,
  output logic                        o_Overflow,
  output logic                        o_Underflow
);

  localparam int unsigned       DIV_W     = $clog2(2 * BCLK_HALF);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * BCLK_HALF - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(BCLK_HALF);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(I2S_SLOTS - 1);

  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   w_div_next;
  logic               r_bclk;
  logic [SLOT_W-1:0]  r_slot;
  logic [SLOT_W-1:0]  w_slot_next;
  lr_chan_e           r_lrclk;
  logic               r_sd;
  logic [FRAME_W-1:0] r_shift;
  sample_t            r_held;
  sample_t            w_held_next;
  sample_t            w_head;
  logic               w_event;
  logic               w_frame_start;
  logic               w_pop;
  logic               w_fifo_empty;
  logic               w_drop;
  logic               r_ovf;
  logic               r_unf;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .i_clk   (i_Clock),
    .i_rst_n (i_Reset_n),
    .i_push  (i_SampleReady),
    .i_data  (i_Sample),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_level (o_FifoLevel),
    .o_drop  (w_drop)
  );

  // Divider wrap marks the BCLK falling edge; the wrap out of slot 31 starts a frame.
  always_comb begin
    w_event       = (r_div == DIV_LAST);
    w_div_next    = w_event ? '0 : r_div + DIV_W'(1);
    w_slot_next   = r_slot + SLOT_W'(1);
    w_frame_start = w_event && (r_slot == SLOT_LAST);
    w_pop         = w_frame_start && !w_fifo_empty;
    w_held_next   = w_pop ? w_head : r_held;
  end

  // Bit clock is registered from the next divider value so it tracks the counter exactly.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_bclk <= (w_div_next >= DIV_HALF);
    end
  end

  // Slot, LRCLK and serial data all advance on BCLK falling edges.
  // SD always takes the shifter MSB before reload/shift, which yields the
  // one-bit I2S delay: slot 0 carries the previous frame's last bit.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_slot  <= SLOT_LAST;
      r_lrclk <= LR_LEFT;
      r_sd    <= 1'b0;
      r_shift <= '0;
      r_held  <= '0;
    end else if (w_event) begin
      r_slot  <= w_slot_next;
      r_lrclk <= slot_channel(w_slot_next);
      r_sd    <= r_shift[FRAME_W-1];
      if (w_frame_start) begin
        r_held  <= w_held_next;
        r_shift <= {w_held_next, w_held_next};
      end else begin
        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // Sticky error flags; a set condition takes priority over a clear.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_drop)                              r_ovf <= 1'b1;
      else if (i_ClearFlags)                   r_ovf <= 1'b0;
      if (w_frame_start && w_fifo_empty)       r_unf <= 1'b1;
      else if (i_ClearFlags)                   r_unf <= 1'b0;
    end
  end

  assign o_BitClock       = r_bclk;
  assign o_LeftRightClock = r_lrclk;
  assign o_SerialData     = r_sd;
  assign o_Overflow       = r_ovf;
  assign o_Underflow      = r_unf;

endmodule
